// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body datapath.
// Latency: none (declarations only).
// Backpressure: none.
package snake_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [1:0] MSM_GAME = 2'b01;

  localparam logic [11:0] COLOUR_HEAD   = 12'hFF0;
  localparam logic [11:0] COLOUR_BODY   = 12'h0F0;
  localparam logic [11:0] COLOUR_TARGET = 12'hF00;
  localparam logic [11:0] COLOUR_BG     = 12'h00F;

  // Packs exactly like TARGET_ADDR: {X, Y}.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/snake_next_head.sv
// Next head position with toroidal wrap at the play-field edges.
// Latency: combinational.
// Backpressure: none.
module snake_next_head
  import snake_pkg::*;
(
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  dir_t           dir,
  input  logic [X_W-1:0] max_x,
  input  logic [Y_W-1:0] max_y,
  output logic [X_W-1:0] nxt_x,
  output logic [Y_W-1:0] nxt_y
);

  always_comb begin
    nxt_x = x;
    nxt_y = y;
    case (dir)
      DIR_UP:    nxt_y = (y == '0)    ? max_y : y - Y_W'(1);
      DIR_DOWN:  nxt_y = (y == max_y) ? '0    : y + Y_W'(1);
      DIR_RIGHT: nxt_x = (x == max_x) ? '0    : x + X_W'(1);
      DIR_LEFT:  nxt_x = (x == '0)    ? max_x : x - X_W'(1);
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_body_control.sv
// Snake segment shift register, growth/collision evaluation and pixel colouring.
// Latency: move on REF edge, evaluation one cycle later, colour one cycle after ADDRESS.
// Backpressure: none; REF is ignored outside GAME or after a self collision.
module snake_body_control
  import snake_pkg::*;
#(
  parameter int MAX_LENGTH  = 32,
  parameter int INIT_LENGTH = 3,
  parameter int MAX_X       = 159,
  parameter int MAX_Y       = 119,
  parameter int START_X     = 80,
  parameter int START_Y     = 100
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [1:0]                          MSM_State,
  input  logic [1:0]                          NSM_State,
  input  logic [14:0]                         TARGET_ADDR,
  input  logic [18:0]                         ADDRESS,
  input  logic                                REF,
  output logic [11:0]                         COLOUR_OUT,
  output logic                                REACHED_TARGET,
  output logic                                SELF_COLLISION,
  output logic [$clog2(MAX_LENGTH+1)-1:0]     SNAKE_LENGTH
);

  localparam int             LEN_W = $clog2(MAX_LENGTH + 1);
  localparam coord_t         START = '{x: X_W'(START_X), y: Y_W'(START_Y)};
  localparam logic [X_W-1:0] LIM_X = X_W'(MAX_X);
  localparam logic [Y_W-1:0] LIM_Y = Y_W'(MAX_Y);

  coord_t         seg [MAX_LENGTH];
  coord_t         head;
  coord_t         target;
  coord_t         pixel;
  coord_t         next_head;
  logic [X_W-1:0] nxt_x;
  logic [Y_W-1:0] nxt_y;
  logic           move_vld;
  logic           eval_vld;
  logic           head_on_target;
  logic           body_hit;
  logic           pix_on_body;
  logic [11:0]    colour_nxt;
  logic           unused_addr_bits;

  assign head             = seg[0];
  assign target           = coord_t'(TARGET_ADDR);
  assign pixel            = '{x: ADDRESS[18:11], y: ADDRESS[8:2]};
  assign unused_addr_bits = ^{ADDRESS[10:9], ADDRESS[1:0]};
  assign move_vld         = REF && (MSM_State == MSM_GAME) && !SELF_COLLISION;
  assign head_on_target   = (head == target);
  assign next_head        = '{x: nxt_x, y: nxt_y};

  snake_next_head u_next_head (
    .x     (head.x),
    .y     (head.y),
    .dir   (dir_t'(NSM_State)),
    .max_x (LIM_X),
    .max_y (LIM_Y),
    .nxt_x (nxt_x),
    .nxt_y (nxt_y)
  );

  // Index 0 is the head itself, so the self-hit search starts at 1.
  always_comb begin
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LENGTH; i++) begin
      if ((LEN_W'(i) < SNAKE_LENGTH) && (seg[i] == head)) body_hit = 1'b1;
    end
  end

  always_comb begin
    pix_on_body = 1'b0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if ((LEN_W'(i) < SNAKE_LENGTH) && (seg[i] == pixel)) pix_on_body = 1'b1;
    end
  end

  always_comb begin
    colour_nxt = COLOUR_BG;
    if (MSM_State == MSM_GAME) begin
      if (pixel == head)        colour_nxt = COLOUR_HEAD;
      else if (pix_on_body)     colour_nxt = COLOUR_BODY;
      else if (pixel == target) colour_nxt = COLOUR_TARGET;
    end
  end

  // Inactive tail entries keep shifting so growth reveals the old tail.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LENGTH; i++) seg[i] <= START;
    end else if (move_vld) begin
      seg[0] <= next_head;
      for (int i = 1; i < MAX_LENGTH; i++) seg[i] <= seg[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      eval_vld       <= 1'b0;
      REACHED_TARGET <= 1'b0;
      SELF_COLLISION <= 1'b0;
      SNAKE_LENGTH   <= LEN_W'(INIT_LENGTH);
      COLOUR_OUT     <= COLOUR_BG;
    end else begin
      eval_vld       <= move_vld;
      REACHED_TARGET <= eval_vld && head_on_target;
      COLOUR_OUT     <= colour_nxt;
      if (eval_vld && head_on_target && (SNAKE_LENGTH != LEN_W'(MAX_LENGTH)))
        SNAKE_LENGTH <= SNAKE_LENGTH + LEN_W'(1);
      if (eval_vld && body_hit)
        SELF_COLLISION <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_body_control.sv
// Bench: two DUTs (default depth and depth 4) share stimulus and are compared
// every cycle against a queue-based reference model, plus directed scenarios.
module tb_snake_body_control;

  localparam int ML0     = 32;
  localparam int ML1     = 4;
  localparam int INIT    = 3;
  localparam int MAX_X   = 159;
  localparam int MAX_Y   = 119;
  localparam int START_X = 80;
  localparam int START_Y = 100;

  logic        CLK;
  logic        RESET;
  logic [1:0]  msm_state;
  logic [1:0]  nsm_state;
  logic [14:0] target_addr;
  logic [18:0] address;
  logic        ref_strobe;

  logic [11:0] col0, col1;
  logic        rt0, rt1, coll0, coll1;
  logic [5:0]  len0;
  logic [2:0]  len1;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: each snake is a queue of packed coordinates (x*128 + y), head first.
  int body [2][$];
  int m_len  [2];
  bit m_coll [2];
  bit m_pend [2];
  bit m_rt   [2];
  int m_col  [2];

  snake_body_control dut0 (
    .CLK(CLK), .RESET(RESET), .MSM_State(msm_state), .NSM_State(nsm_state),
    .TARGET_ADDR(target_addr), .ADDRESS(address), .REF(ref_strobe),
    .COLOUR_OUT(col0), .REACHED_TARGET(rt0), .SELF_COLLISION(coll0), .SNAKE_LENGTH(len0)
  );

  snake_body_control #(.MAX_LENGTH(ML1)) dut1 (
    .CLK(CLK), .RESET(RESET), .MSM_State(msm_state), .NSM_State(nsm_state),
    .TARGET_ADDR(target_addr), .ADDRESS(address), .REF(ref_strobe),
    .COLOUR_OUT(col1), .REACHED_TARGET(rt1), .SELF_COLLISION(coll1), .SNAKE_LENGTH(len1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int xy(input int x, input int y);
    return x * 128 + y;
  endfunction

  function automatic logic [18:0] addr_of(input int c);
    logic [18:0] a;
    a        = '0;
    a[18:11] = 8'(c / 128);
    a[8:2]   = 7'(c % 128);
    return a;
  endfunction

  // Wrap by modular arithmetic on the field size.
  function automatic int nh(input int c, input int d);
    int x;
    int y;
    x = c / 128;
    y = c % 128;
    case (d)
      0: y = (y + MAX_Y) % (MAX_Y + 1);
      1: x = (x + 1) % (MAX_X + 1);
      2: y = (y + 1) % (MAX_Y + 1);
      default: x = (x + MAX_X) % (MAX_X + 1);
    endcase
    return xy(x, y);
  endfunction

  task automatic model_step(input int k);
    int head, pix, tgt, col, ml;
    bit hit_t, hit_b, mv, on_body;
    ml = (k == 0) ? ML0 : ML1;
    if (RESET) begin
      body[k].delete();
      repeat (ml) body[k].push_back(xy(START_X, START_Y));
      m_len[k]  = INIT;
      m_coll[k] = 1'b0;
      m_pend[k] = 1'b0;
      m_rt[k]   = 1'b0;
      m_col[k]  = 'h00F;
    end else begin
      head    = body[k][0];
      tgt     = int'(target_addr);
      pix     = xy(int'(address[18:11]), int'(address[8:2]));
      on_body = 1'b0;
      for (int i = 0; i < m_len[k]; i++) if (body[k][i] == pix) on_body = 1'b1;
      if (msm_state != 2'b01) col = 'h00F;
      else if (pix == head)   col = 'hFF0;
      else if (on_body)       col = 'h0F0;
      else if (pix == tgt)    col = 'hF00;
      else                    col = 'h00F;
      hit_t = m_pend[k] && (head == tgt);
      hit_b = 1'b0;
      for (int i = 1; i < m_len[k]; i++) if (body[k][i] == head) hit_b = m_pend[k];
      mv = ref_strobe && (msm_state == 2'b01) && !m_coll[k];
      m_rt[k] = hit_t;
      if (hit_t && m_len[k] < ml) m_len[k]++;
      if (hit_b) m_coll[k] = 1'b1;
      m_pend[k] = mv;
      m_col[k]  = col;
      if (mv) begin
        body[k].push_front(nh(head, int'(nsm_state)));
        void'(body[k].pop_back());
      end
    end
  endtask

  task automatic check_all();
    chk("colour0", col0, m_col[0]);
    chk("reached0", rt0, m_rt[0]);
    chk("collision0", coll0, m_coll[0]);
    chk("length0", len0, m_len[0]);
    chk("colour1", col1, m_col[1]);
    chk("reached1", rt1, m_rt[1]);
    chk("collision1", coll1, m_coll[1]);
    chk("length1", len1, m_len[1]);
  endtask

  task automatic step();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    ref_strobe = 1'b0;
    step();
    RESET = 1'b0;
  endtask

  // One move cycle followed by its evaluation cycle.
  task automatic move(input int d);
    nsm_state  = 2'(d);
    ref_strobe = 1'b1;
    step();
    ref_strobe = 1'b0;
    step();
  endtask

  task automatic pixel_check(input string tag, input int c, input logic [11:0] exp);
    address = addr_of(c);
    step();
    chk(tag, col0, exp);
  endtask

  int cur_dir;
  int sel;

  initial begin
    RESET       = 1'b1;
    msm_state   = 2'b00;
    nsm_state   = 2'b01;
    target_addr = '0;
    address     = '0;
    ref_strobe  = 1'b0;
    step();
    step();
    chk("rst_len", len0, INIT);
    chk("rst_colour", col0, 12'h00F);
    chk("rst_reached", rt0, 0);
    chk("rst_collision", coll0, 0);
    RESET     = 1'b0;
    msm_state = 2'b01;

    // Horizontal wrap at the right edge.
    repeat (78) move(1);
    move(1);
    pixel_check("wrap_x159", xy(159, 100), 12'hFF0);
    move(1);
    pixel_check("wrap_x0", xy(0, 100), 12'hFF0);
    move(1);
    pixel_check("wrap_x1", xy(1, 100), 12'hFF0);

    // Single eat: one-cycle pulse and growth.
    do_reset();
    target_addr = 15'(xy(81, 100));
    move(1);
    chk("eat_pulse", rt0, 1);
    chk("eat_len", len0, 4);
    step();
    chk("eat_pulse_clear", rt0, 0);
    chk("eat_len_hold", len0, 4);

    // Five eats: depth-4 instance saturates but keeps pulsing.
    do_reset();
    for (int h = 0; h < 5; h++) begin
      target_addr = 15'(xy(81 + h, 100));
      move(1);
      chk("sat_pulse1", rt1, 1);
    end
    chk("sat_len1", len1, 4);
    chk("sat_len0", len0, 8);

    // Tight loop back onto the body.
    do_reset();
    target_addr = 15'(xy(81, 100));
    move(1);
    target_addr = 15'(xy(82, 100));
    move(1);
    target_addr = 15'(xy(0, 0));
    move(1);
    move(2);
    move(3);
    move(0);
    chk("loop_coll_len5", coll0, 1);
    chk("loop_nocoll_len4", coll1, 0);
    move(1);
    pixel_check("frozen_head", xy(82, 100), 12'hFF0);
    chk("frozen_len", len0, 5);

    // Colour priority.
    do_reset();
    target_addr = 15'(xy(81, 100));
    move(1);
    target_addr = 15'(xy(82, 100));
    move(1);
    target_addr = 15'(xy(50, 50));
    pixel_check("col_head", xy(82, 100), 12'hFF0);
    pixel_check("col_body", xy(81, 100), 12'h0F0);
    pixel_check("col_target", xy(50, 50), 12'hF00);
    pixel_check("col_bg", xy(10, 10), 12'h00F);
    target_addr = 15'(xy(82, 100));
    pixel_check("col_head_over_target", xy(82, 100), 12'hFF0);
    msm_state = 2'b00;
    pixel_check("col_not_game", xy(82, 100), 12'h00F);
    msm_state = 2'b01;

    // Reset against REF and against a pending evaluation.
    do_reset();
    target_addr = 15'(xy(81, 100));
    nsm_state   = 2'b01;
    RESET       = 1'b1;
    ref_strobe  = 1'b1;
    step();
    RESET      = 1'b0;
    ref_strobe = 1'b0;
    step();
    chk("rst_ref_pulse", rt0, 0);
    chk("rst_ref_len", len0, INIT);
    pixel_check("rst_ref_head", xy(80, 100), 12'hFF0);
    ref_strobe = 1'b1;
    step();
    ref_strobe = 1'b0;
    RESET      = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_eval_pulse", rt0, 0);
    chk("rst_eval_len", len0, INIT);
    step();
    chk("rst_eval_pulse_late", rt0, 0);
    chk("rst_eval_len_late", len0, INIT);

    // Randomized traffic.
    cur_dir = 1;
    for (int n = 0; n < 4000; n++) begin
      RESET = ($urandom_range(0, 199) == 0) || (m_coll[0] && $urandom_range(0, 15) == 0);
      msm_state  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b01;
      if ($urandom_range(0, 4) == 0) cur_dir = int'($urandom_range(0, 3));
      nsm_state  = 2'(cur_dir);
      ref_strobe = ($urandom_range(0, 2) == 0);
      sel = int'($urandom_range(0, 5));
      if (sel < 2)       target_addr = 15'(nh(body[0][0], cur_dir));
      else if (sel == 2) target_addr = 15'(body[0][0]);
      else if (sel == 3) target_addr = 15'(xy(int'($urandom_range(0, MAX_X)), int'($urandom_range(0, MAX_Y))));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: address = addr_of(body[0][0]);
        1: address = addr_of(body[0][$urandom_range(0, m_len[0] - 1)]);
        2: address = addr_of(int'(target_addr));
        default: address = addr_of(xy(int'($urandom_range(0, MAX_X)), int'($urandom_range(0, MAX_Y))));
      endcase
      address[10:9] = 2'($urandom);
      address[1:0]  = 2'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snake_body_control.md
SNAKE_BODY_CONTROL -- requirements
Module: snake_body_control

Interface
REQ-001 Parameter MAX_LENGTH, default 32, meaning the segment-register depth, which is also the maximum snake length (range 2..128).
REQ-002 Parameter INIT_LENGTH, default 3, meaning the snake length after reset (1..MAX_LENGTH).
REQ-003 Parameter MAX_X, default 159, meaning the largest reduced-resolution X coordinate.
REQ-004 Parameter MAX_Y, default 119, meaning the largest reduced-resolution Y coordinate.
REQ-005 Parameters START_X and START_Y, defaults 80 and 100, meaning the reset position of every segment.
REQ-006 CLK  in  1  sole clock; all logic is clocked on the rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 MSM_State  in  2  master state; 2'b01 = GAME.
REQ-009 NSM_State  in  2  direction: 00 up, 01 right, 10 down, 11 left.
REQ-010 TARGET_ADDR  in  15  target position: [14:7] = X, [6:0] = Y.
REQ-011 ADDRESS  in  19  VGA pixel address: [18:11] = X, [8:2] = Y.
REQ-012 REF  in  1  one-cycle move strobe.
REQ-013 COLOUR_OUT  out  12  registered pixel colour.
REQ-014 REACHED_TARGET  out  1  one-cycle pulse when the snake eats the target.
REQ-015 SELF_COLLISION  out  1  sticky flag set when the head hits the body.
REQ-016 SNAKE_LENGTH  out  clog2(MAX_LENGTH+1)  current active length.

Function
REQ-017 Segment storage: MAX_LENGTH X/Y pairs (8-bit X, 7-bit Y); index 0 is the head; only indices below SNAKE_LENGTH are active.
REQ-018 Move: a move occurs on a REF cycle only when MSM_State = 01 and SELF_COLLISION = 0.
REQ-019 On a move, segment[i] takes segment[i-1] for i = 1..MAX_LENGTH-1, and the head takes the next-head value, all on the same edge.
REQ-020 Next-head wrap: up with Y = 0 goes to MAX_Y; down with Y = MAX_Y goes to 0; right with X = MAX_X goes to 0; left with X = 0 goes to MAX_X; otherwise the coordinate changes by ±1.
REQ-021 Evaluation occurs in the cycle after a move (a registered copy of the move strobe).
REQ-022 In the evaluation cycle, if head = target, REACHED_TARGET is 1 on the next edge for exactly one cycle, and SNAKE_LENGTH increments, saturating at MAX_LENGTH.
REQ-023 Growth exposes the previously shifted-out tail position; no further segment write occurs.
REQ-024 In the evaluation cycle, if head = segment[i] for any 1 ≤ i < SNAKE_LENGTH, SELF_COLLISION is set and stays set until RESET.
REQ-025 If target and collision hit in the same evaluation cycle, both take effect.
REQ-026 REF outside GAME, or while SELF_COLLISION = 1, is ignored; no move and no evaluation occur.
REQ-027 Colour path has one-cycle latency from ADDRESS, and is non-blue only when MSM_State = 01.
REQ-028 Colour priority: head 12'hFF0, then active body 12'h0F0, then target 12'hF00, else 12'h00F.
REQ-029 Body match is a parallel compare across all MAX_LENGTH segments, each gated by index < SNAKE_LENGTH.

Reset
REQ-030 RESET sets all segments to (START_X, START_Y), SNAKE_LENGTH to INIT_LENGTH, REACHED_TARGET and SELF_COLLISION to 0, COLOUR_OUT to 12'h00F, and clears the evaluation strobe.
REQ-031 RESET has priority over REF and evaluation in the same cycle, including a pending evaluation.

Structure
REQ-032 Shared package snake_pkg holds the direction codes, the GAME state code, the four colour constants, and the coordinate widths.
REQ-033 One sub-module, snake_next_head, is combinational wrap arithmetic taking X, Y, direction, MAX_X and MAX_Y and producing the next X and Y.

Verification
REQ-034 Scenario: reset, GAME, direction right, REF from X = 158 → head X goes 159, then 0, then 1; Y stays 100.
REQ-035 Scenario: TARGET_ADDR = {8'd81, 7'd100}, one right move → REACHED_TARGET high for exactly one cycle; SNAKE_LENGTH goes 3 → 4.
REQ-036 Scenario: MAX_LENGTH = 4 and five target hits → SNAKE_LENGTH saturates at 4; REACHED_TARGET still pulses on every hit.
REQ-037 Scenario: length 5 and moves right, down, left, up → SELF_COLLISION = 1; further REF leaves all segments unchanged.
REQ-038 Scenario: ADDRESS at head, body and target pixels, and head over target → colours FF0 / 0F0 / F00 / FF0 one cycle later; MSM_State = 00 gives 00F.
REQ-039 Scenario: RESET asserted together with REF and again in an evaluation cycle → reset values result; no pulse and no growth occur.
